spi_txn_arbiter: RTL and testbench

//  Shares one spi_master byte engine among NUM_REQ requesters. Round-robin grant, per-requester

---
 rtl/spi_txn_arbiter_if.sv | 31 +++
 rtl/spi_txn_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_txn_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_arbiter_if.sv
// Bundle between client requesters, the transaction arbiter and one spi_master byte engine.
// Handshake: req is a level held by a client; a byte is consumed on the tx_ack pulse, rx_data is valid on the rx_valid pulse, and the arbiter issues m_start only while m_busy is low.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic [NUM_REQ*8-1:0]     tx_data;
  logic [NUM_REQ-1:0]       tx_ack;
  logic [7:0]               rx_data;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       cs_n;
  logic                     m_start;
  logic [7:0]               m_data;
  logic                     m_busy;
  logic                     m_new_data;
  logic [7:0]               m_rx;

  modport slave (
    input  req, len, tx_data, m_busy, m_new_data, m_rx,
    output tx_ack, rx_data, rx_valid, grant, done, cs_n, m_start, m_data
  );

  modport master (
    output req, len, tx_data, m_busy, m_new_data, m_rx,
    input  tx_ack, rx_data, rx_valid, grant, done, cs_n, m_start, m_data
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ clients, with per-client chip
// select and CS setup/hold/gap timing around multi-byte transactions.
module spi_txn_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_txn_arbiter_if.slave    bus,
  output logic [2:0]          dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   owner;
  logic [LEN_W:0]     remaining;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic [LEN_W-1:0]   len_win;
  logic [NUM_REQ-1:0] win_onehot;
  int                 idx;

  assign dbg_state = state;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  assign len_win    = bus.len[win*LEN_W +: LEN_W];
  assign win_onehot = NUM_REQ'(1) << win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr           <= '0;
      owner        <= '0;
      remaining    <= '0;
      cnt          <= '0;
      bus.grant    <= '0;
      bus.cs_n     <= '1;
      bus.tx_ack   <= '0;
      bus.rx_valid <= '0;
      bus.done     <= '0;
      bus.m_start  <= 1'b0;
      bus.m_data   <= '0;
      bus.rx_data  <= '0;
    end else begin
      bus.m_start  <= 1'b0;
      bus.tx_ack   <= '0;
      bus.rx_valid <= '0;
      bus.done     <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner     <= win;
            bus.grant <= win_onehot;
            bus.cs_n  <= ~win_onehot;
            // A zero length field encodes the maximum transfer of 2^LEN_W bytes.
            remaining <= (len_win == '0) ? (LEN_W+1)'(1 << LEN_W) : {1'b0, len_win};
            rr        <= (win == IDX_W'(NUM_REQ-1)) ? '0 : IDX_W'(win + 1'b1);
            cnt       <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP-1)) begin
            cnt   <= '0;
            state <= S_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!bus.m_busy) begin
            bus.m_start <= 1'b1;
            bus.m_data  <= bus.tx_data[owner*8 +: 8];
            bus.tx_ack  <= bus.grant;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.m_new_data) begin
            bus.rx_data  <= bus.m_rx;
            bus.rx_valid <= bus.grant;
            remaining    <= remaining - 1'b1;
            cnt          <= '0;
            state        <= (remaining == (LEN_W+1)'(1)) ? S_HOLD : S_ISSUE;
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD-1)) begin
            bus.cs_n  <= '1;
            bus.grant <= '0;
            bus.done  <= bus.grant;
            cnt       <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(CS_GAP-1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a loopback spi_master model (MISO echoes MOSI).
module tb_spi_txn_arbiter;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  spi_txn_arbiter_if #(.NUM_REQ(2), .LEN_W(4)) bus ();

  spi_txn_arbiter #(
    .NUM_REQ(2), .LEN_W(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int acks[2];
  int rxv[2];
  int dones[2];
  int starts = 0, windows = 0, high_run = 0, gap_min = 1000;
  int cs_viol = 0, busy_viol = 0, rx_bad = 0, data_bad = 0;
  bit prev_high = 1'b1;
  logic [7:0] exp_q[$];
  logic [1:0] gs_q[$];
  logic [7:0] e;

  function automatic logic [7:0] tx_byte(input int i, input int n);
    if (i == 0 && n == 0) return 8'hA5;
    if (i == 0 && n == 1) return 8'h3C;
    return 8'(i * 64 + n * 7 + 1);
  endfunction

  assign bus.tx_data = {tx_byte(1, acks[1]), tx_byte(0, acks[0])};

  // ---------------- spi_master model ----------------
  logic       mdl_busy, mdl_nd, force_busy;
  logic [7:0] mdl_rx, mdl_shadow;
  logic [1:0] mdl_cnt;

  assign bus.m_busy     = mdl_busy | force_busy;
  assign bus.m_new_data = mdl_nd;
  assign bus.m_rx       = mdl_rx;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy   <= 1'b0;
      mdl_nd     <= 1'b0;
      mdl_cnt    <= '0;
      mdl_rx     <= '0;
      mdl_shadow <= '0;
    end else begin
      mdl_nd <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 2'd2) begin
          mdl_busy <= 1'b0;
          mdl_nd   <= 1'b1;
          mdl_rx   <= mdl_shadow;
        end else begin
          mdl_cnt <= mdl_cnt + 1'b1;
        end
      end else if (bus.m_start) begin
        mdl_busy   <= 1'b1;
        mdl_cnt    <= '0;
        mdl_shadow <= bus.m_data;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.m_start) begin
        starts++;
        if (bus.m_busy) busy_viol++;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.tx_ack[i]) begin
          if (!bus.m_start || bus.m_data !== tx_byte(i, acks[i])) data_bad++;
          exp_q.push_back(tx_byte(i, acks[i]));
          acks[i]++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.rx_valid[i]) begin
          rxv[i]++;
          if (exp_q.size() == 0) rx_bad++;
          else begin
            e = exp_q.pop_front();
            if (bus.rx_data !== e) rx_bad++;
          end
        end
        if (bus.done[i]) dones[i]++;
      end
    end
    if (bus.cs_n !== ~bus.grant) cs_viol++;
    if ($countones(~bus.cs_n) > 1) cs_viol++;
    if (bus.cs_n != 2'b11) begin
      if (prev_high) begin
        windows++;
        gs_q.push_back(bus.grant);
        if (windows > 1 && high_run < gap_min) gap_min = high_run;
      end
      high_run  = 0;
      prev_high = 1'b0;
    end else begin
      high_run++;
      prev_high = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cur(input int which);
    case (which)
      0:       return dones[0] + dones[1];
      1:       return acks[0];
      2:       return rxv[0];
      default: return (dbg_state == 3'd2) ? 1 : 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string tag);
    int n = 0;
    while (cur(which) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cur(which) >= target), 32'd1);
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int b_start, b_ack0, b_rxv0, b_rxv1, b_done0, b_done1, b_win, b_gs;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.len = '0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_cs_n", 32'(bus.cs_n), 32'h3);
    check("rst_m_start", 32'(bus.m_start), 32'h0);
    check("rst_tx_ack", 32'(bus.tx_ack), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_m_data", 32'(bus.m_data), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Two-byte transaction for requester 0: A5 then 3C.
    bus.len = {4'd1, 4'd2};
    bus.req = 2'b01;
    wait_for(0, 1, 300, "t1_done_seen");
    bus.req = '0;
    check("t1_acks0", 32'(acks[0]), 32'd2);
    check("t1_rxv0", 32'(rxv[0]), 32'd2);
    check("t1_rxv1", 32'(rxv[1]), 32'd0);
    check("t1_done0", 32'(dones[0]), 32'd1);
    check("t1_starts", 32'(starts), 32'd2);
    check("t1_windows", 32'(windows), 32'd1);
    check("t1_grant_win", 32'(gs_q[0]), 32'h1);
    check("t1_last_rx", 32'(bus.rx_data), 32'h3C);
    check("t1_cs_n_idle", 32'(bus.cs_n), 32'h3);
    check("t1_rx_data_ok", 32'(rx_bad), 32'd0);
    repeat (10) @(negedge clk);

    // Both requesters held: grants alternate from pointer 0 after reset.
    pulse_reset(2);
    b_gs = gs_q.size(); b_done0 = dones[0]; b_done1 = dones[1];
    b_rxv0 = rxv[0]; b_rxv1 = rxv[1];
    bus.len = {4'd1, 4'd1};
    bus.req = 2'b11;
    wait_for(0, b_done0 + b_done1 + 4, 400, "t2_four_done");
    bus.req = '0;
    check("t2_grant_a", 32'(gs_q[b_gs]),   32'h1);
    check("t2_grant_b", 32'(gs_q[b_gs+1]), 32'h2);
    check("t2_grant_c", 32'(gs_q[b_gs+2]), 32'h1);
    check("t2_grant_d", 32'(gs_q[b_gs+3]), 32'h2);
    check("t2_gap_min", 32'(gap_min >= 4), 32'd1);
    check("t2_done0", 32'(dones[0] - b_done0), 32'd2);
    check("t2_done1", 32'(dones[1] - b_done1), 32'd2);
    check("t2_rxv1", 32'(rxv[1] - b_rxv1), 32'd2);
    repeat (10) @(negedge clk);

    // len = 0 means 16 bytes in one CS window.
    b_start = starts; b_rxv0 = rxv[0]; b_win = windows; b_ack0 = acks[0];
    bus.len = {4'd1, 4'd0};
    bus.req = 2'b01;
    wait_for(0, dones[0] + dones[1] + 1, 600, "t3_done_seen");
    bus.req = '0;
    check("t3_starts", 32'(starts - b_start), 32'd16);
    check("t3_rxv0", 32'(rxv[0] - b_rxv0), 32'd16);
    check("t3_acks0", 32'(acks[0] - b_ack0), 32'd16);
    check("t3_windows", 32'(windows - b_win), 32'd1);
    repeat (10) @(negedge clk);

    // Request dropped and len changed after the first byte: still 3 bytes.
    b_ack0 = acks[0]; b_rxv0 = rxv[0]; b_done0 = dones[0]; b_done1 = dones[1]; b_win = windows;
    bus.len = {4'd1, 4'd3};
    bus.req = 2'b01;
    wait_for(1, b_ack0 + 1, 100, "t4_first_ack");
    bus.req = '0;
    bus.len = {4'd1, 4'd1};
    wait_for(0, b_done0 + b_done1 + 1, 300, "t4_done_seen");
    check("t4_acks0", 32'(acks[0] - b_ack0), 32'd3);
    check("t4_rxv0", 32'(rxv[0] - b_rxv0), 32'd3);
    check("t4_done0", 32'(dones[0] - b_done0), 32'd1);
    check("t4_done1", 32'(dones[1] - b_done1), 32'd0);
    repeat (20) @(negedge clk);
    check("t4_no_regrant", 32'(windows - b_win), 32'd1);

    // Reset while waiting on byte 2, then a fresh one-byte transaction.
    b_ack0 = acks[0]; b_done0 = dones[0];
    bus.len = {4'd1, 4'd3};
    bus.req = 2'b01;
    wait_for(1, b_ack0 + 2, 200, "t5_second_ack");
    check("t5_in_wait", 32'(dbg_state), 32'd3);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("t5_cs_n", 32'(bus.cs_n), 32'h3);
    check("t5_grant", 32'(bus.grant), 32'h0);
    check("t5_m_start", 32'(bus.m_start), 32'h0);
    check("t5_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_done", 32'(dones[0] - b_done0), 32'd0);
    b_rxv0 = rxv[0];
    bus.len = {4'd1, 4'd1};
    bus.req = 2'b01;
    wait_for(0, dones[0] + dones[1] + 1, 200, "t5_fresh_done");
    bus.req = '0;
    check("t5_fresh_rxv0", 32'(rxv[0] - b_rxv0), 32'd1);
    check("t5_fresh_done0", 32'(dones[0] - b_done0), 32'd1);
    repeat (10) @(negedge clk);

    // m_busy held high while in ISSUE blocks the start pulse.
    b_start = starts; b_ack0 = acks[0];
    force_busy = 1'b1;
    bus.len = {4'd1, 4'd1};
    bus.req = 2'b01;
    wait_for(3, 1, 50, "t6_reach_issue");
    repeat (5) @(negedge clk);
    check("t6_no_start", 32'(starts - b_start), 32'd0);
    check("t6_no_ack", 32'(acks[0] - b_ack0), 32'd0);
    check("t6_still_issue", 32'(dbg_state), 32'd2);
    force_busy = 1'b0;
    wait_for(0, dones[0] + dones[1] + 1, 200, "t6_done_seen");
    bus.req = '0;
    check("t6_one_start", 32'(starts - b_start), 32'd1);
    check("t6_one_ack", 32'(acks[0] - b_ack0), 32'd1);
    repeat (10) @(negedge clk);

    check("cs_invariant", 32'(cs_viol), 32'd0);
    check("start_vs_busy", 32'(busy_viol), 32'd0);
    check("rx_data_all", 32'(rx_bad), 32'd0);
    check("m_data_all", 32'(data_bad), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
